// File: rtl/systolic_drain_if.sv
// Bus bundle for systolic_drain: skewed south inputs from the array and the
// valid/ready result-row stream toward writeback.
interface systolic_drain_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_south0;
    logic [DATA_W-1:0] in_south1;
    logic [DATA_W-1:0] in_south2;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_col0;
    logic [DATA_W-1:0] out_col1;
    logic [DATA_W-1:0] out_col2;
    logic              out_last;

    modport master (
        output in_valid, in_south0, in_south1, in_south2, out_ready,
        input  out_valid, out_col0, out_col1, out_col2, out_last
    );
    modport slave (
        input  in_valid, in_south0, in_south1, in_south2, out_ready,
        output out_valid, out_col0, out_col1, out_col2, out_last
    );
endinterface

// File: rtl/systolic_drain.sv
// Output deskew + drain FIFO for the 3x3 systolic array: realigns staggered
// bottom-row columns into rows, tags tile ends, and never stalls the array.
module systolic_drain #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 4,
    parameter int TILE_ROWS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,   // active-low, asynchronous
    input  logic                     clear_i,
    systolic_drain_if.slave          bus,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] c2;
        logic [DATA_W-1:0] c1;
        logic [DATA_W-1:0] c0;
    } row_t;

    logic [2:1]        vld_q;
    logic [DATA_W-1:0] c0_s1_q, c0_s2_q, c1_s1_q;
    row_t              mem_q [DEPTH];
    logic [AW:0]       wr_q, rd_q, wr_d, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic              row_done, full, empty, pop, push;
    logic [AW:0]       level;
    row_t              row_d, head;

    // Deskew: col0 waits two cycles, col1 one, col2 arrives in the completion cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q   <= '0;
            c0_s1_q <= '0;
            c0_s2_q <= '0;
            c1_s1_q <= '0;
        end else if (clear_i) begin
            vld_q   <= '0;
        end else begin
            vld_q <= {vld_q[1], bus.in_valid};
            if (bus.in_valid) c0_s1_q <= bus.in_south0;
            if (vld_q[1]) begin
                c0_s2_q <= c0_s1_q;
                c1_s1_q <= bus.in_south1;
            end
        end
    end

    always_comb begin
        row_done = vld_q[2];
        level    = wr_q - rd_q;
        empty    = (wr_q == rd_q);
        full     = (level == (AW+1)'(DEPTH));
        pop      = !empty && bus.out_ready;
        // A full FIFO still accepts the row when the head leaves in the same cycle.
        push     = row_done && (!full || pop);
        row_d    = '{last: (cnt_q == CW'(TILE_ROWS-1)),
                     c2: bus.in_south2, c1: c1_s1_q, c0: c0_s2_q};
        wr_d     = push ? wr_q + 1'b1 : wr_q;
        rd_d     = pop  ? rd_q + 1'b1 : rd_q;
        ovf_d    = ovf_q || (row_done && !push);
        cnt_d    = cnt_q;
        if (row_done) cnt_d = (cnt_q == CW'(TILE_ROWS-1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage is zeroed only by reset so the head reads 0 until the first push.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push && !clear_i) begin
            mem_q[wr_q[AW-1:0]] <= row_d;
        end
    end

    assign head          = mem_q[rd_q[AW-1:0]];
    assign bus.out_valid = !empty;
    assign bus.out_col0  = head.c0;
    assign bus.out_col1  = head.c1;
    assign bus.out_col2  = head.c2;
    assign bus.out_last  = head.last;
    assign overflow_o    = ovf_q;
    assign level_o       = level;
endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: skewed-row driver, queue-based reference model,
// a vector table for the basic row/tile cases plus targeted corner sequences.
module tb_systolic_drain;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       overflow;
    logic [2:0] level;

    systolic_drain_if #(.DATA_W(DW)) bus();

    systolic_drain #(.DATA_W(DW), .DEPTH(DEPTH), .TILE_ROWS(3)) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .clear_i    (clear),
        .bus        (bus),
        .overflow_o (overflow),
        .level_o    (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d0, d1, d2;
    } iss_t;
    typedef struct packed {
        logic          last;
        logic [DW-1:0] c0, c1, c2;
    } exp_t;
    typedef struct {
        logic          v;
        logic [DW-1:0] d0, d1, d2;
        logic          rdy, clr;
        logic          ev;
        logic [2:0]    elvl;
        logic          el;
    } vec_t;

    iss_t p0, p1, p2;
    exp_t sbq[$];
    int   mcnt;
    bit   movf;
    int   total, bad;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":out_valid"}, 64'(bus.out_valid), 64'(sbq.size() > 0));
        chk({tag, ":level"}, 64'(level), 64'(sbq.size()));
        chk({tag, ":overflow"}, 64'(overflow), 64'(movf));
        if (sbq.size() > 0) begin
            chk({tag, ":col0"}, 64'(bus.out_col0), 64'(sbq[0].c0));
            chk({tag, ":col1"}, 64'(bus.out_col1), 64'(sbq[0].c1));
            chk({tag, ":col2"}, 64'(bus.out_col2), 64'(sbq[0].c2));
            chk({tag, ":last"}, 64'(bus.out_last), 64'(sbq[0].last));
        end
    endtask

    // One clock: drive skewed inputs, advance the model, then check at the next negedge.
    task automatic step(input logic v, input logic [DW-1:0] d0, d1, d2,
                        input logic rdy, input logic clr, input string tag);
        exp_t e;
        bit   pop, was_full;
        p2 = p1; p1 = p0; p0 = '{v: v, d0: d0, d1: d1, d2: d2};
        bus.in_valid  = v;
        bus.in_south0 = v    ? d0    : DW'($urandom);
        bus.in_south1 = p1.v ? p1.d1 : DW'($urandom);
        bus.in_south2 = p2.v ? p2.d2 : DW'($urandom);
        bus.out_ready = rdy;
        clear         = clr;
        if (clr) begin
            sbq.delete();
            mcnt = 0; movf = 0;
            p0.v = 1'b0; p1.v = 1'b0; p2.v = 1'b0;
        end else begin
            was_full = (sbq.size() == DEPTH);
            pop      = (sbq.size() > 0) && rdy;
            if (pop) void'(sbq.pop_front());
            if (p2.v) begin
                e = '{last: (mcnt == 2), c0: p2.d0, c1: p2.d1, c2: p2.d2};
                mcnt = (mcnt == 2) ? 0 : mcnt + 1;
                if (!was_full || pop) sbq.push_back(e);
                else movf = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check_state(tag);
    endtask

    task automatic idle(input int n, input logic rdy, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, rdy, 1'b0, tag);
    endtask

    task automatic row(input logic [DW-1:0] base, input logic rdy, input string tag);
        step(1'b1, base + 16'h0001, base + 16'h0002, base + 16'h0003, rdy, 1'b0, tag);
    endtask

    initial begin
        total = 0; bad = 0; mcnt = 0; movf = 0;
        p0 = '0; p1 = '0; p2 = '0;
        bus.in_valid = 1'b0; bus.in_south0 = '0; bus.in_south1 = '0;
        bus.in_south2 = '0; bus.out_ready = 1'b0;

        //           v  d0        d1        d2        rdy clr ev lvl last
        tbl[0]  = '{1, 16'h0011, 16'h0022, 16'h0033, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1, 0};
        tbl[3]  = '{0, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0};
        tbl[4]  = '{1, 16'hA001, 16'hB001, 16'hC001, 1, 0, 0, 0, 0};
        tbl[5]  = '{1, 16'hA002, 16'hB002, 16'hC002, 1, 0, 0, 0, 0};
        tbl[6]  = '{1, 16'hA003, 16'hB003, 16'hC003, 1, 0, 1, 1, 0};
        tbl[7]  = '{1, 16'hA004, 16'hB004, 16'hC004, 1, 0, 1, 1, 0};
        tbl[8]  = '{0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 1, 1};
        tbl[9]  = '{0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 1, 1, 0};
        tbl[10] = '{0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0};

        #12;
        chk("reset:out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset:cols", {16'h0, bus.out_col0, bus.out_col1, bus.out_col2}, 64'd0);
        chk("reset:last", 64'(bus.out_last), 64'd0);
        chk("reset:overflow", 64'(overflow), 64'd0);
        chk("reset:level", 64'(level), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single row and tile tagging from the vector table.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy, tbl[i].clr, "tbl");
            chk($sformatf("tbl[%0d]:valid", i), 64'(bus.out_valid), 64'(tbl[i].ev));
            chk($sformatf("tbl[%0d]:level", i), 64'(level), 64'(tbl[i].elvl));
            if (tbl[i].ev) chk($sformatf("tbl[%0d]:last", i), 64'(bus.out_last), 64'(tbl[i].el));
        end
        chk("single:col0_seen", 64'(sbq.size()), 64'd0);

        // Overflow: five rows into a four-deep FIFO with no consumer, then drain.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, "ovf_clr");
        for (int k = 1; k <= 5; k++) row(16'h1000 * k[15:0], 1'b0, "ovf_fill");
        idle(2, 1'b0, "ovf_settle");
        chk("ovf:level_sat", 64'(level), 64'd4);
        chk("ovf:overflow", 64'(overflow), 64'd1);
        idle(5, 1'b1, "ovf_drain");

        // Full FIFO with a pop in the completion cycle of the fifth row: no drop.
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, "pp_clr");
        for (int k = 1; k <= 5; k++) row(16'h2000 * k[15:0], 1'b0, "pp_fill");
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, "pp_wait");
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, "pp_pushpop");
        chk("pp:level_full", 64'(level), 64'd4);
        chk("pp:no_overflow", 64'(overflow), 64'd0);
        idle(5, 1'b1, "pp_drain");

        // clear with two rows stored and one still in the deskew pipe.
        row(16'h3100, 1'b0, "clr_r1");
        row(16'h3200, 1'b0, "clr_r2");
        idle(2, 1'b0, "clr_gap");
        row(16'h3300, 1'b0, "clr_r3");
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, "clr_pulse");
        chk("clr:level", 64'(level), 64'd0);
        chk("clr:valid", 64'(bus.out_valid), 64'd0);
        idle(2, 1'b0, "clr_flush");
        for (int k = 1; k <= 3; k++) row(16'h3400 + k[15:0] * 16'h10, 1'b1, "clr_tile");
        idle(4, 1'b1, "clr_tail");

        // Randomised mix including drops and back-to-back traffic.
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'b0, "rand");
        idle(6, 1'b1, "rand_drain");

        // Asynchronous reset between edges while a row is at the head.
        row(16'h5500, 1'b0, "ar_row");
        idle(2, 1'b0, "ar_wait");
        chk("ar:valid_before", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar:out_valid", 64'(bus.out_valid), 64'd0);
        chk("ar:cols", {16'h0, bus.out_col0, bus.out_col1, bus.out_col2}, 64'd0);
        chk("ar:last", 64'(bus.out_last), 64'd0);
        chk("ar:level", 64'(level), 64'd0);
        chk("ar:overflow", 64'(overflow), 64'd0);
        sbq.delete(); mcnt = 0; movf = 0; p0 = '0; p1 = '0; p2 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        row(16'h6600, 1'b1, "ar_after");
        idle(3, 1'b1, "ar_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/systolic_drain.md
# systolic_drain

Output deskew and drain buffer for the 3x3 weight-stationary systolic array. It captures the three bottom-row south outputs, which arrive staggered one cycle apart per column. It realigns them into one 3-lane result row, tags tile boundaries, and buffers the rows in a small FIFO behind a valid/ready interface toward the writeback path. The array cannot stall, so this block never backpressures its input side; it flags overflow instead.

## Interface
- DATA_W, 16, width of each partial-sum lane
- DEPTH, 4, FIFO depth in rows; power of two, >= 2
- TILE_ROWS, 3, rows per output tile; out_last marks the final row of each tile
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous assert, active-low
- clear  in  1  synchronous flush: empties the FIFO and deskew pipe, zeroes the tile counter, clears overflow
- in_valid  in  1  column-0 result of a row present on in_south0 this cycle
- in_south0, in_south1, in_south2  in  DATA_W each  bottom-row south outputs, columns 0..2
- out_valid  out  1  head row available
- out_ready  in  1  consumer accepts head row when out_valid & out_ready
- out_col0, out_col1, out_col2  out  DATA_W each  head row lanes
- out_last  out  1  head row is the last row of a tile
- overflow  out  1  sticky; a completed row was dropped because the FIFO was full
- level  out  $clog2(DEPTH)+1  rows currently stored

## Operation
- Skew contract: if in_valid=1 in cycle t, column 0 is sampled from in_south0 at t, column 1 from in_south1 at t+1, and column 2 from in_south2 at t+2. in_south1/2 are sampled only in those slots.
- Deskew pipe: col0 delayed 2 stages, col1 delayed 1 stage, col2 direct. The valid bit is delayed 2 stages alongside. in_valid may be asserted every cycle; each row is independent.
- Row completion at cycle t+2: tile counter (0..TILE_ROWS-1) supplies the last tag = (count==TILE_ROWS-1). The counter advances, wrapping to 0 after TILE_ROWS-1, for every completed row, including dropped ones, so tile alignment tracks the array.
- Push: a completed row is written as {last, col2, col1, col0} if not full, or if full with a pop in the same cycle. Otherwise it is dropped, overflow is set to 1, and level is unchanged.
- Pop: out_valid & out_ready advances the read pointer. Pointers wrap modulo DEPTH; full/empty are derived from an extra wrap bit or from level.
- Simultaneous push+pop: level is unchanged. This includes the full case (no overflow) and the empty case (the new row becomes the head at the next cycle; there is no bypass).
- clear has priority over push and pop in the same cycle. Rows in flight in the deskew pipe are discarded. overflow and the tile counter go to 0.
- Reset (rst=0, any time, including mid-row): same effect as clear, applied asynchronously.
- out_col*/out_last are don't-care when out_valid=0. They are 0 from reset until the first push.

## Timing
- Reset values: out_valid=0, out_last=0, out_col0..2=0, overflow=0, level=0.
- Latency: in_valid at cycle t into an empty FIFO gives out_valid=1 with that row at cycle t+3.
- Throughput: one row per cycle in and out sustained. With out_ready held at 1, level stays <= 1.
- out_valid, out_col*, and out_last come from FIFO storage and pointers only, with no combinational path from out_ready.
- level updates one cycle after the push/pop edge. overflow rises in the cycle after the dropped row completes.
- out_ready while out_valid=0 has no effect.

## Test plan
- Single row: in_valid@t with in_south0=0x0011@t, in_south1=0x0022@t+1, in_south2=0x0033@t+2 -> out_valid@t+3 with {col0,col1,col2}={0x0011,0x0022,0x0033}, out_last=0, level=1.
- Tile tagging: 3 back-to-back skewed rows with out_ready=1 -> out_valid high for 3 consecutive cycles from t+3; out_last=1 only on row 3; the 4th row has out_last=0.
- Overflow: out_ready=0, 5 back-to-back rows -> level saturates at 4, overflow=1 after the 5th row completes. Draining yields rows 1..4 in order. On the 5th row, a same-cycle pop instead of a full FIFO -> no overflow.
- Concurrent push/pop at full: FIFO full, out_ready=1 while the next row completes -> level stays 4, overflow stays 0, and the ordering is preserved.
- clear mid-operation: 2 rows stored plus 1 row in the deskew pipe, pulse clear -> next cycle level=0, out_valid=0, overflow=0. The in-flight row never appears, and the next row has the tile count restarted.
- Async reset: drive rst low between clock edges while out_valid=1 -> outputs go to their reset values immediately, without waiting for a clock edge.
